// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared definitions for the data-memory access path:
//                access-size encodings, BRAM write-enable patterns, the
//                controller state type and an alignment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Access size encodings carried on req_size (2'd3 is illegal)
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // The BRAM writes whole words, so only these two patterns are ever used
    localparam logic [3:0] WE_NONE = 4'h0;
    localparam logic [3:0] WE_ALL  = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_DATA = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_e;

    // True when the low offset bits are not aligned to the access size,
    // or when the size encoding itself is illegal.
    function automatic logic size_fault(input logic [1:0] size,
                                        input logic [1:0] off_lo);
        logic fault;
        fault = 1'b0;
        case (size)
            SZ_BYTE: fault = 1'b0;
            SZ_HALF: fault = off_lo[0];
            SZ_WORD: fault = (off_lo != 2'b00);
            default: fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_access_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : dm_access_ctrl_if
//  Description : CPU-side load/store request/response bundle.
//                master : request source (pipeline MEM stage)
//                slave  : data-memory access controller
//  Ports       : req_valid/req_ready handshake, req_we, req_size,
//                req_unsigned, req_addr, req_wdata; resp_valid, resp_rdata,
//                resp_exc (one-cycle completion, no backpressure).
//  Revision    : 1.0 - initial release
// ============================================================================
interface dm_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_exc;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_exc
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_exc
    );
endinterface
`default_nettype wire

// File: rtl/dm_lane_fmt.sv
`default_nettype none
// ============================================================================
//  Module      : dm_lane_fmt
//  Description : Combinational byte-lane formatter for little-endian words.
//                Load side : selects the byte/half lane of the BRAM word and
//                            zero- or sign-extends it.
//                Store side: merges the low byte/half of the store data into
//                            the BRAM word at the selected lane.
//  Ports       : i_size, i_off_lo, i_unsigned, i_rdata, i_wdata ->
//                o_load_data, o_merge_data
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_lane_fmt
    import mem_pkg::*;
(
    input  wire logic [1:0]  i_size,
    input  wire logic [1:0]  i_off_lo,
    input  wire logic        i_unsigned,
    input  wire logic [31:0] i_rdata,
    input  wire logic [31:0] i_wdata,
    output logic      [31:0] o_load_data,
    output logic      [31:0] o_merge_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_off_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_off_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_load_data = i_rdata;
        case (i_size)
            SZ_BYTE: o_load_data = i_unsigned ? {24'h000000, w_byte}
                                              : {{24{w_byte[7]}}, w_byte};
            SZ_HALF: o_load_data = i_unsigned ? {16'h0000, w_half}
                                              : {{16{w_half[15]}}, w_half};
            default: o_load_data = i_rdata;
        endcase
    end

    always_comb begin
        o_merge_data = i_rdata;
        case (i_size)
            SZ_BYTE: begin
                case (i_off_lo)
                    2'd0:    o_merge_data[7:0]   = i_wdata[7:0];
                    2'd1:    o_merge_data[15:8]  = i_wdata[7:0];
                    2'd2:    o_merge_data[23:16] = i_wdata[7:0];
                    default: o_merge_data[31:24] = i_wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (i_off_lo[1]) begin
                    o_merge_data[31:16] = i_wdata[15:0];
                end else begin
                    o_merge_data[15:0]  = i_wdata[15:0];
                end
            end
            default: o_merge_data = i_wdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dm_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dm_access_ctrl
//  Description : Initiator-side controller for the data-memory BRAM.
//                Converts CPU byte/half/word loads and stores into
//                word-indexed BRAM cycles; sub-word stores are performed as
//                read-modify-write because the BRAM writes whole words.
//  Ports       : clk, reset (sync, active-high)
//                bus        : dm_access_ctrl_if.slave request/response
//                bram_we    : write enable, 4'h0 or 4'hF only
//                bram_addr  : word index, zero-extended
//                bram_wdata : write data
//                bram_rdata : read data, 1-cycle registered latency
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH     = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  wire logic        clk,
    input  wire logic        reset,
    dm_access_ctrl_if.slave  bus,
    output logic      [3:0]  bram_we,
    output logic      [31:0] bram_addr,
    output logic      [31:0] bram_wdata,
    input  wire logic [31:0] bram_rdata
);

    // Byte span of the memory; 34 bits so 4*DEPTH cannot wrap
    localparam logic [33:0] c_BYTE_LIMIT = 34'(DEPTH) << 2;

    // ------------------------------------------------------------------
    // Request decode (valid only while a request is being offered)
    // ------------------------------------------------------------------
    logic [31:0] w_off;
    logic        w_exc;

    always_comb begin
        w_off = bus.req_addr - BASE_ADDR;
        w_exc = (bus.req_addr < BASE_ADDR)
              || ({2'b00, w_off} >= c_BYTE_LIMIT)
              || size_fault(bus.req_size, w_off[1:0]);
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_e      state_q,      state_d;
    logic        req_ready_q,  req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_exc_q,   resp_exc_d;
    logic [3:0]  bram_we_q,    bram_we_d;
    logic [31:0] bram_addr_q,  bram_addr_d;
    logic [31:0] bram_wdata_q, bram_wdata_d;

    // Captured request fields
    logic        we_q,       we_d;
    logic [1:0]  size_q,     size_d;
    logic        unsigned_q, unsigned_d;
    logic [1:0]  off_lo_q,   off_lo_d;
    logic [31:0] wdata_q,    wdata_d;

    logic [31:0] w_load_data;
    logic [31:0] w_merge_data;

    dm_lane_fmt u_lane_fmt (
        .i_size       (size_q),
        .i_off_lo     (off_lo_q),
        .i_unsigned   (unsigned_q),
        .i_rdata      (bram_rdata),
        .i_wdata      (wdata_q),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    always_comb begin
        state_d      = state_q;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0000_0000;
        resp_exc_d   = 1'b0;
        bram_we_d    = WE_NONE;
        bram_addr_d  = bram_addr_q;
        bram_wdata_d = bram_wdata_q;
        we_d         = we_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        off_lo_d     = off_lo_q;
        wdata_d      = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    we_d       = bus.req_we;
                    size_d     = bus.req_size;
                    unsigned_d = bus.req_unsigned;
                    off_lo_d   = w_off[1:0];
                    wdata_d    = bus.req_wdata;
                    if (w_exc) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_exc_d   = 1'b1;
                    end else if (bus.req_we && (bus.req_size == SZ_WORD)) begin
                        // Full-word store skips the read phase
                        state_d      = ST_WR;
                        bram_we_d    = WE_ALL;
                        bram_addr_d  = {2'b00, w_off[31:2]};
                        bram_wdata_d = bus.req_wdata;
                    end else begin
                        state_d      = ST_RD;
                        bram_addr_d  = {2'b00, w_off[31:2]};
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end

            ST_RD: begin
                // BRAM samples the address at the edge leaving this state
                state_d = ST_DATA;
            end

            ST_DATA: begin
                if (we_q) begin
                    state_d      = ST_WR;
                    bram_we_d    = WE_ALL;
                    bram_wdata_d = w_merge_data;
                end else begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = w_load_data;
                end
            end

            ST_WR: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
            end

            ST_RESP: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            resp_exc_q   <= 1'b0;
            bram_we_q    <= WE_NONE;
            bram_addr_q  <= 32'h0000_0000;
            bram_wdata_q <= 32'h0000_0000;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            off_lo_q     <= 2'b00;
            wdata_q      <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_exc_q   <= resp_exc_d;
            bram_we_q    <= bram_we_d;
            bram_addr_q  <= bram_addr_d;
            bram_wdata_q <= bram_wdata_d;
            we_q         <= we_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            off_lo_q     <= off_lo_d;
            wdata_q      <= wdata_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_exc   = resp_exc_q;
    assign bram_we        = bram_we_q;
    assign bram_addr      = bram_addr_q;
    assign bram_wdata     = bram_wdata_q;

endmodule
`default_nettype wire

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Initiator-side controller for the data-memory block RAM. It turns CPU load/store requests (byte/half/word, signed/unsigned, valid/ready handshake) into word-indexed BRAM port cycles.
- The BRAM has 1-cycle registered read latency and writes whole words whenever any write-enable bit is set. Sub-word stores are therefore done as read-modify-write.
- Sits between the pipeline's MEM stage and the data BRAM.

Parameters:
- DEPTH, 4096, BRAM depth in 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address that maps to word index 0.

Ports:
- clk  in  1  system clock; also drives the BRAM clka.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and raises an exception.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and exceptions.
- resp_exc  out  1  misaligned, out-of-range or illegal-size request.
- bram_we  out  4  to BRAM wea; only 4'h0 or 4'hF.
- bram_addr  out  32  to BRAM addra; word index, zero-extended.
- bram_wdata  out  32  to BRAM dina.
- bram_rdata  in  32  from BRAM douta.

Behaviour:
- Reset: state IDLE, every output 0 including req_ready, captured request registers cleared. Reset mid-operation abandons the request with no response. A write already on the port completes at that edge. No further write is issued.
- req_ready = 1 only in IDLE when not in reset. A request is accepted at a clock edge where req_valid && req_ready. All request fields are registered at that edge.
- Offset off = req_addr - BASE_ADDR. Word index = off >> 2.
- Exception when any of:
  - req_addr < BASE_ADDR.
  - off >= 4*DEPTH.
  - req_size == 3.
  - half with off[0] != 0.
  - word with off[1:0] != 0.
- On exception: no BRAM cycle; go directly to RESP with resp_exc=1, resp_rdata=0.
- Byte lanes are little-endian: byte k = bits [8k+7:8k] with k = off[1:0]; half h = bits [16h+15:16h] with h = off[1].
- FSM states: IDLE, RD, DATA, WR, RESP.
  - IDLE -> RD: load or sub-word store.
  - IDLE -> WR: word store.
  - IDLE -> RESP: exception.
  - RD: bram_addr = index, bram_we = 0. BRAM captures douta at the exiting edge. -> DATA.
  - DATA, load: extract the lane, extend per req_unsigned, register into resp_rdata. -> RESP.
  - DATA, sub-word store: merge the low byte/half of req_wdata into bram_rdata at the selected lane, register into the write buffer. -> WR.
  - WR: bram_we = 4'hF, bram_addr = index, bram_wdata = buffer (req_wdata for a word store). -> RESP.
  - RESP: resp_valid = 1 for exactly one cycle, resp_exc as computed. -> IDLE.
- Latency from the accept edge to the cycle with resp_valid high:
  - exception: 1 cycle.
  - word store: 2 cycles.
  - load: 3 cycles.
  - sub-word store: 4 cycles.
- Next acceptance is possible the cycle after RESP, because req_ready is 0 in RESP. No back-to-back overlap.
- bram_we is 0 in every state except WR. bram_addr and bram_wdata hold their last value when idle.
- No response backpressure: the consumer must take resp_valid when it occurs.
- Requests are not buffered: req_valid while req_ready = 0 is ignored and must be held by the source.

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_BYTE / SZ_HALF / SZ_WORD.
  - FSM state typedef.
  - WE_NONE = 4'h0, WE_ALL = 4'hF.
- One sub-module, dm_lane_fmt (combinational): load extract/extend and store merge from size, offset[1:0] and unsigned flag. The FSM stays in dm_access_ctrl.

Test Plan:
- Word store 0xDEADBEEF @0x10, then load word @0x10 -> bram_addr = 4, bram_we = F for exactly one cycle; load resp_rdata = 0xDEADBEEF, resp_exc = 0, load latency 3.
- Word 0x11223344 at 0x20, then sb 0xAB @0x21 -> RD, DATA and WR states visible; BRAM word becomes 0x1122AB44; resp after 4 cycles.
- Word 0x80FF7F01 @0x30: lb @0x32 -> 0xFFFFFFFF; lbu @0x32 -> 0x000000FF; lh @0x32 -> 0xFFFF80FF; lhu @0x30 -> 0x00007F01.
- lw @0x0002, sh @0x0001, size = 3, addr = 4*DEPTH -> resp_exc = 1, resp_rdata = 0, bram_we never asserted, latency 1.
- Assert reset during WR of an sb -> at most that single write lands, no resp_valid, all outputs 0 the next cycle, req_ready = 1 once reset drops.
- req_valid held high across three back-to-back loads -> each accepted only in IDLE, responses in order, req_ready = 0 from accept through RESP.
